rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Parametrised, registered N-channel data selector. Successor to the combinational 32-bit mux family.
- Adds a valid/ready handshake, a one-entry output register, and two selection modes: round-robin arbitration or fixed select.
- Sits between multiple producers (e.g. register-file read ports, memory return paths) and a single consumer.
- One word is forwarded per cycle, with the source channel index attached.

Parameters:
DATA_WIDTH, 32, width of each data channel in bits.
NUM_CH, 4, number of input channels; legal range 2..32, need not be a power of two.
SEL_WIDTH, 2, width of channel index; must equal ceil(log2(NUM_CH)).

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RST  input  1  synchronous reset, active-low; sampled on rising CLK edge.
MODE  input  1  0 = round-robin arbitration, 1 = fixed select.
FIX_SEL  input  SEL_WIDTH  channel index used when MODE=1.
IN_VALID  input  NUM_CH  per-channel valid; bit i belongs to channel i.
IN_DATA  input  NUM_CH*DATA_WIDTH  packed data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
IN_READY  output  NUM_CH  per-channel ready; at most one bit set.
OUT_VALID  output  1  output register holds a valid word.
OUT_DATA  output  DATA_WIDTH  registered data word.
OUT_CH  output  SEL_WIDTH  index of the channel that supplied OUT_DATA.
OUT_READY  input  1  consumer accepts OUT_DATA this cycle.

Behaviour:
- Reset (RST=0 at a clock edge):
  - OUT_VALID=0, OUT_DATA=0, OUT_CH=0, priority pointer PTR=0.
  - Takes priority over every other event, including an in-flight handshake; a held word is discarded.
- Load enable: LOAD = ~OUT_VALID | OUT_READY (combinational).
- Grant, MODE=0 (round-robin):
  - Grant the first channel with IN_VALID set, scanning PTR, PTR+1, ... NUM_CH-1, 0, ... PTR-1.
  - No valid channel means no grant.
- Grant, MODE=1 (fixed select):
  - Grant channel FIX_SEL only if IN_VALID[FIX_SEL]=1.
  - If FIX_SEL >= NUM_CH, there is no grant.
  - Other channels are never granted.
- IN_READY[i] = LOAD & grant[i]. It is combinational, one-hot or all-zero, and may depend on IN_VALID.
- Producer handshake:
  - A transfer on channel i occurs when IN_VALID[i] & IN_READY[i] at a clock edge.
  - A producer must hold IN_VALID and its data until the transfer occurs.
- Clock edge with LOAD=1 and a grant to channel g:
  - OUT_VALID<=1, OUT_DATA<=channel g data, OUT_CH<=g. Latency is 1 cycle, input to output.
  - MODE=0: PTR<=(g+1) mod NUM_CH, wrapping from NUM_CH-1 to 0 (no power-of-two assumption).
  - MODE=1: PTR unchanged.
- Clock edge with LOAD=1 and no grant: OUT_VALID<=0; OUT_DATA, OUT_CH and PTR hold.
- Clock edge with LOAD=0 (OUT_VALID=1 and OUT_READY=0):
  - All registers hold. OUT_DATA and OUT_CH are stable while stalled.
  - All IN_READY bits are 0.
- Throughput: one word per cycle while OUT_READY=1 and a grant exists. Consume and reload happen in the same cycle with no bubble.
- MODE and FIX_SEL are sampled combinationally each cycle:
  - A mode change takes effect on the next grant.
  - PTR keeps its value across mode changes.
- A consumer asserting OUT_READY while OUT_VALID=0 has no effect beyond enabling LOAD.
- OUT_* are driven only from registers; no combinational path from IN_* to OUT_*.

Test Plan:
- Reset: hold RST=0 for 2 cycles with all IN_VALID=1 -> OUT_VALID=0, OUT_DATA=0, OUT_CH=0, IN_READY=0. After release, first grant is ch0.
- Round-robin fairness: NUM_CH=4, MODE=0, all IN_VALID=1, IN_DATA[i]=32'hA0+i, OUT_READY=1 for 8 cycles -> OUT_CH sequence 0,1,2,3,0,1,2,3 with matching data, no bubbles.
- Backpressure: word from ch2 in output, OUT_READY=0 for 3 cycles -> OUT_DATA/OUT_CH stable, IN_READY=0. OUT_READY=1 -> next grant is ch3 in the same cycle the held word is consumed.
- Sparse/wrap: PTR=3, only IN_VALID[1]=1 -> ch1 granted, PTR becomes 2. Then only ch0 valid -> ch0 granted after wrap.
- Fixed mode: MODE=1, FIX_SEL=2, all valid -> only ch2 ever granted, PTR unchanged. FIX_SEL=2 with IN_VALID[2]=0 -> OUT_VALID falls to 0 after consume.
- Mid-operation reset: OUT_VALID=1 holding 32'hDEAD, RST=0 for one edge -> OUT_VALID=0, OUT_DATA=0, PTR=0, no IN_READY asserted that cycle.

Source files
------------

// File: rtl/rr_arb_mux.sv
// Registered N-channel selector: round-robin or fixed-select grant, valid/ready
// on every producer and on the consumer, one-entry output register.
module rr_arb_mux #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned SEL_WIDTH  = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         MODE,
    input  logic [SEL_WIDTH-1:0]         FIX_SEL,
    input  logic [NUM_CH-1:0]            IN_VALID,
    input  logic [NUM_CH*DATA_WIDTH-1:0] IN_DATA,
    output logic [NUM_CH-1:0]            IN_READY,
    output logic                         OUT_VALID,
    output logic [DATA_WIDTH-1:0]        OUT_DATA,
    output logic [SEL_WIDTH-1:0]         OUT_CH,
    input  logic                         OUT_READY
);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_WIDTH-1:0]  out_ch_q,    out_ch_d;
    logic [SEL_WIDTH-1:0]  ptr_q,       ptr_d;

    logic                  load_c;
    logic                  grant_vld_c;
    logic [SEL_WIDTH-1:0]  grant_idx_c;
    logic [DATA_WIDTH-1:0] grant_data_c;
    logic [NUM_CH-1:0]     grant_oh_c;
    int unsigned           dist_c;
    int unsigned           best_c;

    assign load_c = ~out_valid_q | OUT_READY;

    // Grant selection: fixed channel, or the valid channel nearest PTR going upward with wrap.
    always_comb begin
        grant_vld_c  = 1'b0;
        grant_idx_c  = '0;
        grant_data_c = '0;
        grant_oh_c   = '0;
        dist_c       = 0;
        best_c       = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (MODE) begin
                if (IN_VALID[i] && (32'(FIX_SEL) == i)) begin
                    grant_vld_c  = 1'b1;
                    grant_idx_c  = SEL_WIDTH'(i);
                    grant_data_c = IN_DATA[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end else if (IN_VALID[i]) begin
                dist_c = (i >= 32'(ptr_q)) ? (i - 32'(ptr_q)) : (i + NUM_CH - 32'(ptr_q));
                if (!grant_vld_c || (dist_c < best_c)) begin
                    grant_vld_c  = 1'b1;
                    grant_idx_c  = SEL_WIDTH'(i);
                    grant_data_c = IN_DATA[i*DATA_WIDTH +: DATA_WIDTH];
                    best_c       = dist_c;
                end
            end
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            grant_oh_c[i] = grant_vld_c && (32'(grant_idx_c) == i);
        end
    end

    // No producer sees ready while reset is asserted, since nothing is captured then.
    assign IN_READY = (RST && load_c) ? grant_oh_c : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load_c) begin
            out_valid_d = grant_vld_c;
            if (grant_vld_c) begin
                out_data_d = grant_data_c;
                out_ch_d   = grant_idx_c;
                if (!MODE) begin
                    ptr_d = ((32'(grant_idx_c) + 1) >= NUM_CH) ? '0
                                                               : grant_idx_c + SEL_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_CH    = out_ch_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux (4 channels x 32 bits): reset, round-robin,
// backpressure, sparse/wrap, fixed select, and reset in mid-operation.
module tb_rr_arb_mux;

    logic         clk;
    logic         rst;
    logic         mode;
    logic [1:0]   fix_sel;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_ch;
    logic         out_ready;

    int passed = 0;
    int total  = 0;

    rr_arb_mux #(.DATA_WIDTH(32), .NUM_CH(4), .SEL_WIDTH(2)) dut (
        .CLK(clk), .RST(rst), .MODE(mode), .FIX_SEL(fix_sel),
        .IN_VALID(in_valid), .IN_DATA(in_data), .IN_READY(in_ready),
        .OUT_VALID(out_valid), .OUT_DATA(out_data), .OUT_CH(out_ch),
        .OUT_READY(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_data();
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + 32'(i);
    endtask

    task automatic do_reset();
        rst = 1'b0; mode = 1'b0; fix_sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
        set_default_data();
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; mode = 1'b0; fix_sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
        set_default_data();
        tick(); tick();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
        total++; if (out_data !== 32'h0) $display("FAIL reset_out_data got=%h exp=0", out_data); else passed++;
        total++; if (out_ch !== 2'd0) $display("FAIL reset_out_ch got=%0d exp=0", out_ch); else passed++;
        total++; if (in_ready !== 4'b0000) $display("FAIL reset_in_ready got=%b exp=0000", in_ready); else passed++;
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0001) $display("FAIL reset_first_ready got=%b exp=0001", in_ready); else passed++;
        tick();
        total++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 32'hA0)
            $display("FAIL reset_first_grant got v=%b ch=%0d d=%h exp v=1 ch=0 d=a0", out_valid, out_ch, out_data);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            exp_rdy = 4'b0001 << (c % 4);
            #1;
            total++; if (in_ready !== exp_rdy) $display("FAIL rr_ready[%0d] got=%b exp=%b", c, in_ready, exp_rdy); else passed++;
            tick();
            total++; if (out_valid !== 1'b1 || out_ch !== 2'(c % 4) || out_data !== 32'hA0 + 32'(c % 4))
                $display("FAIL rr_out[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                         c, out_valid, out_ch, out_data, c % 4, 32'hA0 + 32'(c % 4));
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        tick(); tick(); tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (in_ready !== 4'b0000) $display("FAIL bp_ready[%0d] got=%b exp=0000", c, in_ready); else passed++;
            tick();
            total++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 32'hA2)
                $display("FAIL bp_hold[%0d] got v=%b ch=%0d d=%h exp v=1 ch=2 d=a2", c, out_valid, out_ch, out_data);
            else passed++;
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b1000) $display("FAIL bp_release_ready got=%b exp=1000", in_ready); else passed++;
        tick();
        total++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 32'hA3)
            $display("FAIL bp_release_out got v=%b ch=%0d d=%h exp v=1 ch=3 d=a3", out_valid, out_ch, out_data);
        else passed++;
    endtask

    task automatic test_sparse_wrap();
        do_reset();
        tick(); tick(); tick();
        in_valid = 4'b0010;
        #1;
        total++; if (in_ready !== 4'b0010) $display("FAIL sparse_ready got=%b exp=0010", in_ready); else passed++;
        tick();
        total++; if (out_ch !== 2'd1 || out_data !== 32'hA1) $display("FAIL sparse_out got ch=%0d d=%h exp ch=1 d=a1", out_ch, out_data); else passed++;
        in_valid = 4'b0001;
        tick();
        total++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 32'hA0)
            $display("FAIL wrap_out got v=%b ch=%0d d=%h exp v=1 ch=0 d=a0", out_valid, out_ch, out_data);
        else passed++;
        in_valid = 4'b1011;
        tick();
        total++; if (out_ch !== 2'd1) $display("FAIL wrap_next_ch got=%0d exp=1", out_ch); else passed++;
        in_valid = 4'b0000;
        #1;
        total++; if (in_ready !== 4'b0000) $display("FAIL idle_ready got=%b exp=0000", in_ready); else passed++;
        tick();
        total++; if (out_valid !== 1'b0 || out_ch !== 2'd1 || out_data !== 32'hA1)
            $display("FAIL idle_out got v=%b ch=%0d d=%h exp v=0 ch=1 d=a1", out_valid, out_ch, out_data);
        else passed++;
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 1'b1; fix_sel = 2'd2;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++; if (in_ready !== 4'b0100) $display("FAIL fix_ready[%0d] got=%b exp=0100", c, in_ready); else passed++;
            tick();
            total++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 32'hA2)
                $display("FAIL fix_out[%0d] got v=%b ch=%0d d=%h exp v=1 ch=2 d=a2", c, out_valid, out_ch, out_data);
            else passed++;
        end
        mode = 1'b0;
        tick();
        total++; if (out_ch !== 2'd0 || out_data !== 32'hA0) $display("FAIL fix_ptr_kept got ch=%0d d=%h exp ch=0 d=a0", out_ch, out_data); else passed++;
        mode = 1'b1; fix_sel = 2'd2; in_valid = 4'b1011;
        #1;
        total++; if (in_ready !== 4'b0000) $display("FAIL fix_invalid_ready got=%b exp=0000", in_ready); else passed++;
        tick();
        total++; if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_data !== 32'hA0)
            $display("FAIL fix_invalid_out got v=%b ch=%0d d=%h exp v=0 ch=0 d=a0", out_valid, out_ch, out_data);
        else passed++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        in_data[32 +: 32] = 32'hDEAD;
        in_valid = 4'b0010;
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 32'hDEAD) $display("FAIL midrst_load got v=%b d=%h exp v=1 d=dead", out_valid, out_data); else passed++;
        in_valid = 4'hF; out_ready = 1'b1; rst = 1'b0;
        #1;
        total++; if (in_ready !== 4'b0000) $display("FAIL midrst_ready got=%b exp=0000", in_ready); else passed++;
        tick();
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ch !== 2'd0)
            $display("FAIL midrst_out got v=%b ch=%0d d=%h exp v=0 ch=0 d=0", out_valid, out_ch, out_data);
        else passed++;
        rst = 1'b1;
        set_default_data();
        #1;
        total++; if (in_ready !== 4'b0001) $display("FAIL midrst_ptr_ready got=%b exp=0001", in_ready); else passed++;
        tick();
        total++; if (out_ch !== 2'd0 || out_data !== 32'hA0) $display("FAIL midrst_ptr_out got ch=%0d d=%h exp ch=0 d=a0", out_ch, out_data); else passed++;
    endtask

    initial begin
        rst = 1'b0; mode = 1'b0; fix_sel = 2'd0; in_valid = 4'h0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_sparse_wrap();
        test_fixed();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
